wb_regfile_scoreboard: RTL
==========================

// Module: wb_regfile_scoreboard
// PURPOSE
//   Register file and scoreboard that sit directly downstream of the writeback demux.
//   Consume the single writeback port (regdest/writereg/wbvalue) arbitrated from units x, y, m.
//   Provide two operand read ports, with same-cycle writeback bypass, to the issue stage.
//   Track per-register pending writes from multicycle units; stall issue on RAW/WAW hazards.
// PARAMETERS
//   NREGS   32  number of architectural registers; address width fixed at 5 bits
//   WIDTH   32  data width of registers and writeback value
// PORTS
//   clock           in   1      rising-edge clock
//   reset           in   1      synchronous, active-high reset
//   rs_addr         in   5      read port A address
//   rt_addr         in   5      read port B address
//   rs_data         out  32     read port A data (combinational)
//   rt_data         out  32     read port B data (combinational)
//   rs_pending      out  1      rs_addr has an outstanding write
//   rt_pending      out  1      rt_addr has an outstanding write
//   issue_valid     in   1      issue stage presents an instruction this cycle
//   issue_writereg  in   1      that instruction will write a register
//   issue_regdest   in   5      its destination register
//   issue_stall     out  1      instruction must be held; not accepted this cycle
//   wb_writereg     in   1      writeback valid
//   wb_regdest      in   5      writeback destination
//   wb_wbvalue      in   32     writeback data
//   pending_count   out  6      number of set scoreboard bits (0..31)
// BEHAVIOUR
//   Reset (synchronous; dominates all other inputs in the same cycle):
//   - All registers, all scoreboard bits and pending_count go to 0.
//   - Outputs follow combinationally: rs_data/rt_data/pending flags 0, issue_stall 0.
//   Register 0:
//   - Always reads 0 and is never pending.
//   - Writes and issues targeting it do not modify state.
//   Write: on the clock edge, if wb_writereg && wb_regdest!=0, regs[wb_regdest] <= wb_wbvalue.
//   Read (combinational, zero latency): data = 0 if addr==0;
//   - else wb_wbvalue if wb_writereg && wb_regdest==addr (bypass);
//   - else regs[addr].
//   clr = wb_writereg && wb_regdest!=0 (clears sb[wb_regdest] this cycle).
//   x_pending = sb[x] && !(clr && wb_regdest==x), for x in rs, rt, issue_regdest.
//   issue_stall = issue_valid && (rs_pending || rt_pending || (issue_writereg && dest_pending)).
//   accept = issue_valid && !issue_stall && issue_writereg && issue_regdest!=0.
//   Scoreboard update per edge:
//   - clear sb[wb_regdest] on clr.
//   - set sb[issue_regdest] on accept.
//   - Same register set and cleared in one cycle: set wins (new producer outstanding).
//   pending_count:
//   - +1 on accept; -1 on clr with sb[wb_regdest] previously set.
//   - Both in one cycle: unchanged.
//   - Writeback to a non-pending register: data written, count unchanged.
//   - Never wraps: at most 31 bits can be set.
//   No internal FSM beyond scoreboard/count; a stalled issue retries every cycle.
// TESTING
//   1) reset, read rs=5,rt=0 -> rs_data=0, rt_data=0, pending_count=0, issue_stall=0.
//   2) wb r7=0xDEADBEEF, rs_addr=7 same cycle -> rs_data=0xDEADBEEF (bypass); next cycle still.
//   3) issue dest r3 accepted; next cycle issue reading rs=3 -> issue_stall=1, rs_pending=1;
//      then wb r3=0x11 -> stall drops that cycle, rs_data=0x11, pending_count 1->0.
//   4) sb[r4] set, same cycle wb r4 and new issue dest r4 -> no stall, sb[r4]=1, count unchanged.
//   5) wb r0=0x1234 and issue dest r0 -> rs(0) reads 0, sb unchanged, count 0.
//   6) set r1,r2,r9 pending (count=3), assert reset with wb r1 -> all 0 next cycle, r1 reads 0.

Source files
------------

// File: rtl/wb_regfile_scoreboard_if.sv
// Issue/read/writeback bus between the issue stage (master) and the
// register file + scoreboard (slave).
interface wb_regfile_scoreboard_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             rs_pending;
  logic             rt_pending;
  logic             issue_valid;
  logic             issue_writereg;
  logic [4:0]       issue_regdest;
  logic             issue_stall;
  logic             wb_writereg;
  logic [4:0]       wb_regdest;
  logic [WIDTH-1:0] wb_wbvalue;
  logic [5:0]       pending_count;

  modport master (
    output rs_addr, rt_addr, issue_valid, issue_writereg, issue_regdest,
           wb_writereg, wb_regdest, wb_wbvalue,
    input  rs_data, rt_data, rs_pending, rt_pending, issue_stall, pending_count
  );

  modport slave (
    input  rs_addr, rt_addr, issue_valid, issue_writereg, issue_regdest,
           wb_writereg, wb_regdest, wb_wbvalue,
    output rs_data, rt_data, rs_pending, rt_pending, issue_stall, pending_count
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Register file with same-cycle writeback bypass plus a per-register
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
module wb_regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  wb_regfile_scoreboard_if.slave bus
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] sb;
  logic [5:0]       count;

  logic clr, accept, dec;
  logic rs_byp, rt_byp;
  logic rs_pend, rt_pend, dest_pend;

  assign clr = bus.wb_writereg && (bus.wb_regdest != 5'd0);

  // A writeback landing this cycle already resolves the hazard it clears.
  assign rs_pend   = sb[bus.rs_addr]       && !(clr && bus.wb_regdest == bus.rs_addr);
  assign rt_pend   = sb[bus.rt_addr]       && !(clr && bus.wb_regdest == bus.rt_addr);
  assign dest_pend = sb[bus.issue_regdest] && !(clr && bus.wb_regdest == bus.issue_regdest);

  assign bus.rs_pending  = rs_pend;
  assign bus.rt_pending  = rt_pend;
  assign bus.issue_stall = bus.issue_valid &&
                           (rs_pend || rt_pend || (bus.issue_writereg && dest_pend));

  assign accept = bus.issue_valid && !bus.issue_stall && bus.issue_writereg &&
                  (bus.issue_regdest != 5'd0);
  assign dec    = clr && sb[bus.wb_regdest];

  assign rs_byp = bus.wb_writereg && (bus.wb_regdest == bus.rs_addr);
  assign rt_byp = bus.wb_writereg && (bus.wb_regdest == bus.rt_addr);

  assign bus.rs_data = (bus.rs_addr == 5'd0) ? '0 :
                       rs_byp ? bus.wb_wbvalue : regs[bus.rs_addr];
  assign bus.rt_data = (bus.rt_addr == 5'd0) ? '0 :
                       rt_byp ? bus.wb_wbvalue : regs[bus.rt_addr];

  assign bus.pending_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      sb    <= '0;
      count <= '0;
    end else begin
      if (clr) begin
        regs[bus.wb_regdest] <= bus.wb_wbvalue;
        sb[bus.wb_regdest]   <= 1'b0;
      end
      // Set after clear: a new producer issued this cycle stays outstanding.
      if (accept) sb[bus.issue_regdest] <= 1'b1;
      count <= count + {5'd0, accept} - {5'd0, dec};
    end
  end
endmodule
